rgb565_gray_packer: RTL and testbench
=====================================

// Module: rgb565_gray_packer
// PURPOSE
//  Streaming stage between the camera pixel interface and the frame-buffer DMA.
//  - Converts each incoming RGB565 pixel to 8-bit grayscale, using the same weights as
//    the grayscale custom instruction.
//  - Packs four gray bytes into one 32-bit word and buffers the words in a small FIFO.
//  - The DMA drains the FIFO through a valid/ready handshake.
//  - The camera side cannot stall, so overflow is detected, never back-pressured.
// PARAMETERS
//  FIFO_DEPTH  8  number of 32-bit words buffered; power of two, >= 2
// PORTS
//  clock          in   1   system clock; all logic on rising edge
//  reset          in   1   synchronous, active-high reset
//  pixelValid     in   1   pixelData valid this cycle
//  pixelData      in   16  RGB565 pixel: R[15:11], G[10:5], B[4:0]
//  frameEnd       in   1   qualifies pixelValid; marks the last pixel of a frame
//  wordValid      out  1   FIFO head word available
//  wordData       out  32  packed gray bytes; oldest pixel in [7:0]
//  wordLast       out  1   head word is the last word of a frame
//  wordReady      in   1   consumer accepts head word when wordValid & wordReady
//  overflow       out  1   sticky: a word was dropped because the FIFO was full
//  clearOverflow  in   1   synchronous clear of overflow (clear wins over a new set)
// BEHAVIOUR
//  - Reset: all outputs 0 (wordValid, wordData, wordLast, overflow); FIFO empty;
//    byte counter 0; pipeline valids 0. Reset mid-frame discards the partial word.
//  - Arithmetic:
//    r6 = {R,0}, g6 = G, b6 = {B,0};
//    sum[13:0] = r6*54 + g6*183 + b6*19 (max 16055, never overflows 14 bits);
//    gray = sum[13:6] (truncate, no rounding).
//  - Stage 1 (cycle N+1): the three products are registered with valid and frameEnd.
//    Stage 2 (cycle N+2): sum and gray are registered with valid and frameEnd.
//  - Packer: 2-bit byteCnt. Each stage-2 valid writes gray into byte lane byteCnt.
//    - A push is requested when byteCnt==3 or the stage-2 frameEnd is set.
//    - A frameEnd push zero-fills the unused upper lanes and sets the word's last flag.
//    - After a push, byteCnt returns to 0.
//  - FIFO: a push becomes visible on wordValid/wordData at cycle N+3 (registered
//    write, show-ahead read). A pop occurs on wordValid & wordReady.
//    - Push and pop in the same cycle are both performed, including when full.
//    - At full with no pop, the pushed word is dropped and overflow is set on the
//      next edge. FIFO contents and pointers stay unchanged.
//    - Empty: wordValid=0; wordData/wordLast hold their last value and are don't-care.
//  - pixelValid=0 inserts bubbles; pipeline and packer state are held.
//    frameEnd without pixelValid is ignored.
//  - Words are never reordered. wordData/wordLast stay stable while
//    wordValid & !wordReady.
// STRUCTURE
//  - Shared header gray_defs.vh: weight constants (W_R=54, W_G=183, W_B=19),
//    GRAY_SHIFT=6, SUM_WIDTH=14. The grayscale custom instruction must use the
//    same constants.
//  - One sub-module, gray_word_fifo: parameterised depth, 33-bit entries
//    {last, data}, push/pop/full/empty, simultaneous push+pop at full.
//  - Converter pipeline and packer live in this module.
// TESTING
//  1. Pixels 0xFFFF, 0x0000, 0xF800, 0x07E0, wordReady=1 -> one word 0xB4_34_00_FA
//     (250, 0, 52, 180) at 3 cycles after the 4th pixel; wordLast=0.
//  2. Pixels 0x001F, 0x001F, then 0x001F with frameEnd -> word 0x00_12_12_12,
//     wordLast=1; next frame's first byte lands in lane 0.
//  3. wordReady=0, 4*(FIFO_DEPTH+1) pixels -> FIFO_DEPTH words held, overflow=1;
//     drain returns the first FIFO_DEPTH words in order; clearOverflow -> 0.
//  4. FIFO full, wordReady=1 while a push arrives -> no drop, overflow stays 0,
//     occupancy unchanged.
//  5. Gaps of 0-5 idle cycles between 8 pixels -> identical 2 words as back-to-back.
//  6. reset asserted after 2 pixels of a word -> outputs 0, FIFO empty; next 4 pixels
//     form a clean word starting in lane 0.

Source files
------------

// File: rtl/rgb565_gray_packer_pkg.sv
// Shared grayscale definitions: luma weights, sum width and the packed FIFO entry.
// The grayscale custom instruction imports the same constants so both paths agree bit for bit.
package rgb565_gray_packer_pkg;

    localparam int W_R        = 54;
    localparam int W_G        = 183;
    localparam int W_B        = 19;
    localparam int GRAY_SHIFT = 6;
    localparam int SUM_WIDTH  = 14;
    localparam int WORD_BYTES = 4;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } gray_word_t;

    // Truncating scale-down of the weighted sum to an 8-bit gray level.
    function automatic logic [7:0] gray_of_sum(input logic [SUM_WIDTH-1:0] sum);
        return 8'(sum >> GRAY_SHIFT);
    endfunction

endpackage

// File: rtl/gray_word_fifo.sv
// Word FIFO with registered head (show-ahead): a push is visible on the head one edge later.
// Simultaneous push and pop is accepted even when full; a push at full without a pop is refused.
module gray_word_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 33
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             push_ok;
    logic             pop_ok;
    logic             empty;
    logic             valid_next;
    logic [WIDTH-1:0] head_next;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        rd_ptr_next = rd_ptr_reg + AW'(pop_ok);
        count_next  = count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        valid_next  = (count_next != '0);
        head_next   = head_data;
        // The incoming word becomes the head when nothing older survives this edge.
        if (push_ok && (count_reg == (AW+1)'(pop_ok))) begin
            head_next = push_data;
        end else if (valid_next) begin
            head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_valid <= valid_next;
            head_data  <= head_next;
        end
    end

endmodule

// File: rtl/rgb565_gray_packer.sv
// Camera-to-DMA stage: two-stage RGB565->gray pipeline, 4-byte packer and word FIFO.
// The camera cannot stall, so a full FIFO drops the word and raises a sticky overflow flag.
module rgb565_gray_packer
    import rgb565_gray_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pixelValid,
    input  logic [15:0] pixelData,
    input  logic        frameEnd,
    output logic        wordValid,
    output logic [31:0] wordData,
    output logic        wordLast,
    input  logic        wordReady,
    output logic        overflow,
    input  logic        clearOverflow
);

    logic [5:0]           r6;
    logic [5:0]           g6;
    logic [5:0]           b6;
    logic                 s1_valid_reg;
    logic                 s1_last_reg;
    logic [SUM_WIDTH-1:0] prod_r_reg;
    logic [SUM_WIDTH-1:0] prod_g_reg;
    logic [SUM_WIDTH-1:0] prod_b_reg;
    logic [SUM_WIDTH-1:0] sum_next;
    logic                 s2_valid_reg;
    logic                 s2_last_reg;
    logic [7:0]           gray_reg;
    logic [1:0]           byte_cnt_reg;
    logic [2:0][7:0]      lanes_reg;
    logic [3:0][7:0]      push_lane;
    logic                 push_req;
    logic                 pop;
    logic                 fifo_full;
    logic                 overflow_reg;
    gray_word_t           push_word;
    gray_word_t           head_word;

    assign r6 = {pixelData[15:11], 1'b0};
    assign g6 = pixelData[10:5];
    assign b6 = {pixelData[4:0], 1'b0};

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            prod_r_reg   <= '0;
            prod_g_reg   <= '0;
            prod_b_reg   <= '0;
        end else begin
            s1_valid_reg <= pixelValid;
            s1_last_reg  <= pixelValid && frameEnd;
            if (pixelValid) begin
                prod_r_reg <= SUM_WIDTH'(r6) * SUM_WIDTH'(W_R);
                prod_g_reg <= SUM_WIDTH'(g6) * SUM_WIDTH'(W_G);
                prod_b_reg <= SUM_WIDTH'(b6) * SUM_WIDTH'(W_B);
            end
        end
    end

    assign sum_next = prod_r_reg + prod_g_reg + prod_b_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
            gray_reg     <= '0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            s2_last_reg  <= s1_last_reg;
            if (s1_valid_reg) begin
                gray_reg <= gray_of_sum(sum_next);
            end
        end
    end

    assign push_req = s2_valid_reg && ((byte_cnt_reg == 2'd3) || s2_last_reg);

    // Lanes below the counter are already filled, the current lane takes the new byte,
    // and lanes above it are zero so a short frame-end word is zero-filled.
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
        if (gi < WORD_BYTES - 1) begin : g_stored
            assign push_lane[gi] = (2'(gi) < byte_cnt_reg)  ? lanes_reg[gi] :
                                   (2'(gi) == byte_cnt_reg) ? gray_reg : 8'h00;
        end else begin : g_top
            assign push_lane[gi] = (byte_cnt_reg == 2'(gi)) ? gray_reg : 8'h00;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt_reg <= '0;
            lanes_reg    <= '0;
        end else if (s2_valid_reg) begin
            if (push_req) begin
                byte_cnt_reg <= '0;
            end else begin
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
                for (int i = 0; i < WORD_BYTES - 1; i++) begin
                    if (byte_cnt_reg == 2'(i)) begin
                        lanes_reg[i] <= gray_reg;
                    end
                end
            end
        end
    end

    assign push_word.last = s2_last_reg;
    assign push_word.data = push_lane;
    assign pop            = wordValid && wordReady;

    gray_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(gray_word_t))
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push_req),
        .push_data  (push_word),
        .pop        (pop),
        .head_valid (wordValid),
        .head_data  (head_word),
        .full       (fifo_full)
    );

    assign wordData = head_word.data;
    assign wordLast = head_word.last;

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (clearOverflow) begin
            overflow_reg <= 1'b0;
        end else if (push_req && fifo_full && !pop) begin
            overflow_reg <= 1'b1;
        end
    end

    assign overflow = overflow_reg;

endmodule

// File: tb/tb_rgb565_gray_packer.sv
// Directed bench for rgb565_gray_packer: a reference gray/packing model fills a scoreboard queue
// as pixels are driven; a monitor pops and compares each word the DUT hands over.
module tb_rgb565_gray_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic        pixelValid;
    logic [15:0] pixelData;
    logic        frameEnd;
    logic        wordValid;
    logic [31:0] wordData;
    logic        wordLast;
    logic        wordReady;
    logic        overflow;
    logic        clearOverflow;

    int          checks = 0;
    int          errors = 0;
    int          pop_count = 0;
    int          pc0;
    logic [32:0] exp_q [$];
    logic [7:0]  m_lane [4];
    int          m_cnt = 0;
    bit          m_drop = 0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_word = '0;
    logic [15:0] gap_pixels [8];

    always #5 clock = ~clock;

    rgb565_gray_packer #(.FIFO_DEPTH(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .pixelValid    (pixelValid),
        .pixelData     (pixelData),
        .frameEnd      (frameEnd),
        .wordValid     (wordValid),
        .wordData      (wordData),
        .wordLast      (wordLast),
        .wordReady     (wordReady),
        .overflow      (overflow),
        .clearOverflow (clearOverflow)
    );

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_gray(input logic [15:0] p);
        int s;
        s = int'({p[15:11], 1'b0}) * 54 + int'(p[10:5]) * 183 + int'({p[4:0], 1'b0}) * 19;
        return 8'(s >> 6);
    endfunction

    task automatic model_pixel(input logic [15:0] p, input logic fe);
        logic [31:0] w;
        m_lane[m_cnt] = ref_gray(p);
        if (m_cnt == 3 || fe) begin
            w = '0;
            for (int i = 0; i <= m_cnt; i++) w[i*8 +: 8] = m_lane[i];
            if (!m_drop) exp_q.push_back({fe, w});
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [15:0] p, input logic fe);
        pixelValid = 1'b1;
        pixelData  = p;
        frameEnd   = fe;
        model_pixel(p, fe);
        step();
        pixelValid = 1'b0;
        frameEnd   = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 200;
        wordReady = 1'b1;
        while (exp_q.size() != 0 && budget > 0) begin
            step();
            budget--;
        end
        idle(2);
        wordReady = 1'b0;
        check("drain_left", 33'(exp_q.size()), 33'd0);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (prev_stall && wordValid) check("stable_head", {wordLast, wordData}, prev_word);
            if (wordValid && wordReady) begin
                if (exp_q.size() == 0) begin
                    check("spurious_word", 33'(wordValid), 33'd0);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("word", {wordLast, wordData}, e);
                    pop_count++;
                    $display("word %0d data=%h last=%b", pop_count, wordData, wordLast);
                end
            end
            prev_stall = wordValid && !wordReady;
            prev_word  = {wordLast, wordData};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        reset = 1'b1; pixelValid = 1'b0; pixelData = '0; frameEnd = 1'b0;
        wordReady = 1'b0; clearOverflow = 1'b0;
        gap_pixels = '{16'h1234, 16'hABCD, 16'h7BEF, 16'h0841, 16'hF81F, 16'h07FF, 16'h5555, 16'hC618};
        idle(3);
        check("rst_valid", 33'(wordValid), 33'd0);
        check("rst_data", 33'(wordData), 33'd0);
        check("rst_last", 33'(wordLast), 33'd0);
        check("rst_ovf", 33'(overflow), 33'd0);
        reset = 1'b0;
        idle(1);

        // 1: four pixels, head appears three cycles after the fourth
        wordReady = 1'b1;
        send(16'hFFFF, 0); send(16'h0000, 0); send(16'hF800, 0); send(16'h07E0, 0);
        check("t1_valid_n1", 33'(wordValid), 33'd0);
        idle(1);
        check("t1_valid_n2", 33'(wordValid), 33'd0);
        idle(1);
        check("t1_valid_n3", 33'(wordValid), 33'd1);
        check("t1_data", 33'(wordData), 33'h0B43400FA);
        check("t1_last", 33'(wordLast), 33'd0);
        drain();

        // 2: short frame-end word, next frame restarts in lane 0
        wordReady = 1'b1;
        send(16'h001F, 0); send(16'h001F, 0); send(16'h001F, 1);
        idle(2);
        check("t2_data", 33'(wordData), 33'h000121212);
        check("t2_last", 33'(wordLast), 33'd1);
        send(16'hFFFF, 0); send(16'h0000, 0); send(16'h0000, 0); send(16'h0000, 0);
        idle(2);
        check("t2_next_data", 33'(wordData), 33'h0000000FA);
        drain();

        // 3: overflow with consumer stalled
        wordReady = 1'b0;
        for (int i = 0; i < 36; i++) begin
            m_drop = (i >= 32);
            send(16'(i * 16'h1357 + 16'h0421), 0);
        end
        m_drop = 0;
        idle(4);
        check("t3_ovf", 33'(overflow), 33'd1);
        check("t3_valid", 33'(wordValid), 33'd1);
        pc0 = pop_count;
        drain();
        check("t3_count", 33'(pop_count - pc0), 33'd8);
        check("t3_ovf_sticky", 33'(overflow), 33'd1);
        clearOverflow = 1'b1;
        step();
        clearOverflow = 1'b0;
        check("t3_ovf_clr", 33'(overflow), 33'd0);

        // 4: push and pop together at full
        wordReady = 1'b0;
        for (int i = 0; i < 32; i++) send(16'(i * 16'h2F11 + 16'h0777), 0);
        idle(4);
        check("t4_full_noovf", 33'(overflow), 33'd0);
        send(16'h1111, 0); send(16'h2222, 0); send(16'h3333, 0); send(16'h4444, 0);
        idle(1);
        wordReady = 1'b1;
        idle(1);
        wordReady = 1'b0;
        idle(3);
        check("t4_ovf", 33'(overflow), 33'd0);
        pc0 = pop_count;
        drain();
        check("t4_count", 33'(pop_count - pc0), 33'd8);

        // 5: random idle gaps between pixels
        wordReady = 1'b1;
        pc0 = pop_count;
        for (int i = 0; i < 8; i++) begin
            send(gap_pixels[i], 0);
            idle($urandom_range(0, 5));
        end
        drain();
        check("t5_count", 33'(pop_count - pc0), 33'd2);

        // 6: reset mid-word
        wordReady = 1'b1;
        send(16'hFFFF, 0); send(16'hF800, 0);
        reset = 1'b1;
        step();
        m_cnt = 0;
        check("t6_valid", 33'(wordValid), 33'd0);
        check("t6_data", 33'(wordData), 33'd0);
        check("t6_last", 33'(wordLast), 33'd0);
        check("t6_ovf", 33'(overflow), 33'd0);
        idle(3);
        reset = 1'b0;
        idle(1);
        pc0 = pop_count;
        send(16'h07E0, 0); send(16'h0000, 0); send(16'h001F, 0); send(16'hFFFF, 0);
        idle(2);
        check("t6_clean_data", 33'(wordData), 33'h0FA1200B4);
        drain();
        check("t6_count", 33'(pop_count - pc0), 33'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
